// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction-memory arbiter slice:
//   - arbiter state encoding (ARB / LOCK)
//   - read-return owner encoding (NONE / IFU / LD)
//   - default memory geometry (256 lines x 128 bits)
// No ports; imported by imem_arbiter and its sub-blocks.
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int IMEM_ADDR_W = 8;
    localparam int IMEM_DATA_W = 128;
    localparam int PERF_W      = 16;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_e;

    typedef enum logic [1:0] {
        NONE = 2'b00,
        IFU  = 2'b01,
        LD   = 2'b10
    } rd_owner_e;

endpackage

// File: rtl/imem_arb_wait_cnt.sv
// -----------------------------------------------------------------------------
// imem_arb_wait_cnt
// Saturating up-counter. Used as the loader wait counter and, when the
// performance build is enabled, as the conflict / starvation counters.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (count -> 0)
//   inc        : increment by one this cycle (ignored once saturated)
//   clr        : clear to zero this cycle (wins over inc)
//   cnt        : current count
//   sat        : count equals MAX
// -----------------------------------------------------------------------------
module imem_arb_wait_cnt #(
    parameter int          WIDTH = 4,
    parameter int unsigned MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    assign sat = (cnt == MAX_V);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !sat) begin
            cnt <= cnt + WIDTH'(1);
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// -----------------------------------------------------------------------------
// imem_arbiter
// Shares the single-port instruction memory between the IFU fetch path and
// the program loader. The IFU has default priority; a wait counter forces a
// loader win after MAX_WAIT consecutive denied loader cycles; ld_lock lets the
// loader own the memory exclusively for burst preload.
//
// Handshake: each requester raises *_req with a stable address (and write
// data for the loader) and holds them until *_gnt is seen high in the same
// cycle; the access is consumed on that cycle's clock edge. Grants are
// combinational and at most one is high per cycle. Read data returns on the
// owner's port one cycle after the grant, with *_rvld high for one cycle.
//
// Ports:
//   clk, rst_n                     clock, asynchronous active-low reset
//   ifu_req/ifu_addr               IFU read request and line address
//   ifu_gnt, ifu_rvld, ifu_rdata   IFU grant and read return
//   ld_req/ld_we/ld_addr/ld_wdata  loader request, direction, address, data
//   ld_lock                        loader asks for exclusive ownership
//   ld_gnt, ld_rvld, ld_rdata      loader grant and read return
//   mem_ce/mem_we/mem_addr/mem_din memory drive
//   mem_dout                       memory read data (1-cycle latency)
//   locked                         arbiter is in LOCK state
//
// Optional build macro IMEM_ARB_PERF_EN adds conflict_cnt[15:0] (cycles with
// both requests high) and starve_cnt[15:0] (forced loader wins), both
// saturating. Arbitration is identical with or without the macro.
// -----------------------------------------------------------------------------
module imem_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_WIDTH = IMEM_ADDR_W,
    parameter int DATA_WIDTH = IMEM_DATA_W,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ifu_req,
    input  logic [ADDR_WIDTH-1:0] ifu_addr,
    output logic                  ifu_gnt,
    output logic                  ifu_rvld,
    output logic [DATA_WIDTH-1:0] ifu_rdata,
    input  logic                  ld_req,
    input  logic                  ld_we,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [DATA_WIDTH-1:0] ld_wdata,
    input  logic                  ld_lock,
    output logic                  ld_gnt,
    output logic                  ld_rvld,
    output logic [DATA_WIDTH-1:0] ld_rdata,
    output logic                  mem_ce,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,
    output logic                  locked
`ifdef IMEM_ARB_PERF_EN
    ,
    output logic [PERF_W-1:0]     conflict_cnt,
    output logic [PERF_W-1:0]     starve_cnt
`endif
);

    arb_state_e state_q;
    rd_owner_e  rd_owner_q;

    logic [3:0] wait_cnt;
    logic       wait_sat;
    logic       wait_inc;
    logic       wait_clr;

    // ------------------------------------------------------------------
    // Grant decision
    // ------------------------------------------------------------------
    always_comb begin
        ifu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (state_q == LOCK) begin
            ld_gnt = ld_req;
        end else begin
            // Loader wins when the IFU is idle or it has waited MAX_WAIT cycles.
            ld_gnt  = ld_req && (!ifu_req || wait_sat);
            ifu_gnt = ifu_req && !ld_gnt;
        end
    end

    // Counter stays at zero in LOCK; in ARB it counts denied loader cycles.
    assign wait_inc = ld_req && !ld_gnt;
    assign wait_clr = (state_q == LOCK) || ld_gnt || !ld_req;

    imem_arb_wait_cnt #(
        .WIDTH (4),
        .MAX   (MAX_WAIT)
    ) u_wait_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (wait_inc),
        .clr   (wait_clr),
        .cnt   (wait_cnt),
        .sat   (wait_sat)
    );

    // Only the saturation flag drives arbitration; the count itself is for
    // observation.
    logic unused_wait;
    assign unused_wait = &{1'b0, wait_cnt};

    // ------------------------------------------------------------------
    // Memory drive
    // ------------------------------------------------------------------
    assign mem_ce   = ifu_gnt || ld_gnt;
    assign mem_we   = ld_gnt && ld_we;
    assign mem_addr = ld_gnt ? ld_addr : ifu_addr;
    assign mem_din  = mem_we ? ld_wdata : '0;

    // ------------------------------------------------------------------
    // State and read-owner registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ARB;
            rd_owner_q <= NONE;
        end else begin
            case (state_q)
                ARB:     if (ld_gnt && ld_lock) state_q <= LOCK;
                LOCK:    if (!ld_lock)          state_q <= ARB;
                default:                        state_q <= ARB;
            endcase

            if (ifu_gnt) begin
                rd_owner_q <= IFU;
            end else if (ld_gnt && !ld_we) begin
                rd_owner_q <= LD;
            end else begin
                rd_owner_q <= NONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Read return: straight decodes of the owner / state flops
    // ------------------------------------------------------------------
    assign ifu_rvld  = (rd_owner_q == IFU);
    assign ld_rvld   = (rd_owner_q == LD);
    assign ifu_rdata = ifu_rvld ? mem_dout : '0;
    assign ld_rdata  = ld_rvld  ? mem_dout : '0;
    assign locked    = (state_q == LOCK);

`ifdef IMEM_ARB_PERF_EN
    logic conflict_sat;
    logic starve_sat;
    logic starve_inc;

    // In ARB a loader grant with the IFU also requesting can only come from
    // the wait counter forcing it.
    assign starve_inc = (state_q == ARB) && ld_gnt && ifu_req;

    imem_arb_wait_cnt #(
        .WIDTH (PERF_W),
        .MAX   (32'h0000_FFFF)
    ) u_conflict_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (ifu_req && ld_req),
        .clr   (1'b0),
        .cnt   (conflict_cnt),
        .sat   (conflict_sat)
    );

    imem_arb_wait_cnt #(
        .WIDTH (PERF_W),
        .MAX   (32'h0000_FFFF)
    ) u_starve_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (starve_inc),
        .clr   (1'b0),
        .cnt   (starve_cnt),
        .sat   (starve_sat)
    );

    logic unused_perf;
    assign unused_perf = &{1'b0, conflict_sat, starve_sat};
`endif

endmodule
